program_loader: RTL and testbench

- Boot-time loader that sits directly upstream of the processor's word-addressed RAM write port.
- Accepts a byte stream from a host link (UART receiver or testbench) over a valid/ready handshake.
- Assembles bytes into 32-bit little-endian words and writes them into consecutive RAM addresses starting at a base address.
- Holds the CPU halted until the requested number of words has been written.

---
 rtl/program_loader_if.sv | 41 ++++
 rtl/program_loader.sv | 158 +++++++++++++++
 tb/tb_program_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : program_loader_if
// Description : Byte-stream handshake from the host link plus the RAM word
//               write port driven by the program loader.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface program_loader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    // Host byte stream
    logic              i_byte_valid;
    logic [7:0]        i_byte;
    logic              o_byte_ready;
    // RAM write port
    logic              o_set;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_data;

    // Loader side
    modport slave (
        input  i_byte_valid,
        input  i_byte,
        output o_byte_ready,
        output o_set,
        output o_addr,
        output o_data
    );

    // Host / RAM side
    modport master (
        output i_byte_valid,
        output i_byte,
        input  o_byte_ready,
        input  o_set,
        input  o_addr,
        input  o_data
    );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : program_loader
// Description : Boot-time loader. Packs a host byte stream into 32-bit
//               little-endian words and writes them to consecutive RAM
//               addresses from a base address, holding the CPU halted
//               (o_busy) until the requested word count has been written.
//               DATA_W must be 32 (four bytes per word).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module program_loader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst_n,
    input  wire logic              i_start,
    input  wire logic [ADDR_W-1:0] i_base_addr,
    input  wire logic [ADDR_W-1:0] i_word_count,
    input  wire logic              i_abort,
    program_loader_if.slave        bus,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_aborted
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_WORD = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;          // next RAM address to write
    logic [ADDR_W-1:0]   remain_q, remain_d;      // words still to write
    logic [1:0]          byte_cnt_q, byte_cnt_d;  // byte index within word
    logic [DATA_W-1:0]   word_q, word_d;          // word being assembled
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;  // RAM address presented
    logic [DATA_W-1:0]   out_data_q, out_data_d;  // RAM data presented
    logic                aborted_q, aborted_d;

    logic                write_en;
    logic                byte_ready;
    logic                busy;
    logic                done;

    // State and datapath registers; reset discards any partial word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            aborted_q  <= aborted_d;
        end
    end

    // Next-state logic and per-state outputs; abort outranks bytes and writes
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        aborted_d  = 1'b0;
        write_en   = 1'b0;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d     = i_base_addr;
                    remain_d   = i_word_count;
                    byte_cnt_d = '0;
                    word_d     = '0;
                    state_d    = (i_word_count != '0) ? S_COLLECT : S_DONE;
                end
            end

            S_COLLECT: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (i_abort) begin
                    aborted_d  = 1'b1;
                    byte_cnt_d = '0;
                    word_d     = '0;
                    state_d    = S_IDLE;
                end else if (bus.i_byte_valid) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = bus.i_byte;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Capture the RAM-side address/data now so they are
                        // valid throughout WRITE and hold afterwards.
                        out_addr_d = addr_q;
                        out_data_d = word_d;
                        state_d    = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                busy = 1'b1;
                if (i_abort) begin
                    aborted_d  = 1'b1;
                    byte_cnt_d = '0;
                    word_d     = '0;
                    state_d    = S_IDLE;
                end else begin
                    write_en   = 1'b1;
                    addr_d     = addr_q + ONE_WORD;
                    remain_d   = remain_q - ONE_WORD;
                    byte_cnt_d = '0;
                    word_d     = '0;
                    state_d    = (remain_q == ONE_WORD) ? S_DONE : S_COLLECT;
                end
            end

            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.o_byte_ready = byte_ready;
    assign bus.o_set        = write_en;
    assign bus.o_addr       = out_addr_q;
    assign bus.o_data       = out_data_q;
    assign o_busy           = busy;
    assign o_done           = done;
    assign o_aborted        = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_program_loader;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_count;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;

    program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_base_addr  (base_addr),
        .i_word_count (word_count),
        .i_abort      (abort),
        .bus          (bus.slave),
        .o_busy       (busy),
        .o_done       (done),
        .o_aborted    (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // RAM-side monitor: records every write the RAM would perform
    logic [ADDR_W-1:0] wr_addr[$];
    logic [DATA_W-1:0] wr_data[$];
    int wr_cnt    = 0;
    int done_cnt  = 0;
    int abort_cnt = 0;
    int rdy_in_wr = 0;

    always @(posedge clk) begin
        if (bus.o_set) begin
            wr_addr.push_back(bus.o_addr);
            wr_data.push_back(bus.o_data);
            wr_cnt <= wr_cnt + 1;
            if (bus.o_byte_ready) rdy_in_wr <= rdy_in_wr + 1;
        end
        if (done)    done_cnt  <= done_cnt + 1;
        if (aborted) abort_cnt <= abort_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with start deasserted
    task automatic start_load(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c);
        start      = 1'b1;
        base_addr  = b;
        word_count = c;
        @(negedge clk);
        start      = 1'b0;
        base_addr  = $urandom;
        word_count = $urandom;
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.i_byte_valid = 1'b1;
        bus.i_byte       = b;
        while (!bus.o_byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.o_byte_ready) check("byte_timeout", 64'd0, 64'd1);
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        bus.i_byte       = $urandom;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("idle_timeout", 64'd1, 64'd0);
    endtask

    int w0, d0, a0;

    initial begin
        // ---------------- reset state with random inputs ----------------
        rst_n            = 1'b0;
        start            = 1'($urandom);
        base_addr        = $urandom;
        word_count       = $urandom;
        abort            = 1'($urandom);
        bus.i_byte_valid = 1'($urandom);
        bus.i_byte       = $urandom;
        repeat (3) @(negedge clk);
        check("rst_busy",    64'(busy),             64'd0);
        check("rst_done",    64'(done),             64'd0);
        check("rst_aborted", 64'(aborted),          64'd0);
        check("rst_set",     64'(bus.o_set),        64'd0);
        check("rst_ready",   64'(bus.o_byte_ready), 64'd0);
        check("rst_addr",    64'(bus.o_addr),       64'd0);
        check("rst_data",    64'(bus.o_data),       64'd0);

        start            = 1'b0;
        abort            = 1'b0;
        bus.i_byte_valid = 1'b0;
        rst_n            = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_write", 64'(wr_cnt), 64'd0);
        check("idle_busy",     64'(busy),   64'd0);

        // ---------------- single-word load ----------------
        start_load(16'h0010, 16'd1);
        check("sw_busy",  64'(busy),             64'd1);
        check("sw_ready", 64'(bus.o_byte_ready), 64'd1);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        check("sw_set",      64'(bus.o_set),        64'd1);
        check("sw_addr",     64'(bus.o_addr),       64'h0010);
        check("sw_data",     64'(bus.o_data),       64'h12345678);
        check("sw_wr_ready", 64'(bus.o_byte_ready), 64'd0);
        @(negedge clk);
        check("sw_done",      64'(done),       64'd1);
        check("sw_set_off",   64'(bus.o_set),  64'd0);
        check("sw_busy_done", 64'(busy),       64'd1);
        check("sw_addr_hold", 64'(bus.o_addr), 64'h0010);
        @(negedge clk);
        check("sw_done_off", 64'(done), 64'd0);
        check("sw_idle",     64'(busy), 64'd0);

        // ---------------- multi-word with random stalls ----------------
        w0 = wr_cnt;
        d0 = done_cnt;
        start_load(16'h0000, 16'd3);
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(8'(i + 1));
        end
        wait_idle();
        @(negedge clk);
        check("mw_count", 64'(wr_cnt - w0),   64'd3);
        check("mw_a0",    64'(wr_addr[w0]),   64'h0000);
        check("mw_d0",    64'(wr_data[w0]),   64'h04030201);
        check("mw_a1",    64'(wr_addr[w0+1]), 64'h0001);
        check("mw_d1",    64'(wr_data[w0+1]), 64'h08070605);
        check("mw_a2",    64'(wr_addr[w0+2]), 64'h0002);
        check("mw_d2",    64'(wr_data[w0+2]), 64'h0C0B0A09);
        check("mw_rdy_in_write", 64'(rdy_in_wr), 64'd0);
        check("mw_one_done", 64'(done_cnt - d0), 64'd1);

        // ---------------- address wrap ----------------
        w0 = wr_cnt;
        start_load(16'hFFFF, 16'd2);
        for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i));
        wait_idle();
        @(negedge clk);
        check("wr_count", 64'(wr_cnt - w0),   64'd2);
        check("wr_a0",    64'(wr_addr[w0]),   64'hFFFF);
        check("wr_d0",    64'(wr_data[w0]),   64'hA3A2A1A0);
        check("wr_a1",    64'(wr_addr[w0+1]), 64'h0000);
        check("wr_d1",    64'(wr_data[w0+1]), 64'hA7A6A5A4);

        // ---------------- zero count ----------------
        w0 = wr_cnt;
        bus.i_byte_valid = 1'b1;
        bus.i_byte       = 8'hEE;
        start_load(16'h1234, 16'd0);
        check("zc_done",  64'(done),             64'd1);
        check("zc_ready", 64'(bus.o_byte_ready), 64'd0);
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        check("zc_done_off", 64'(done),         64'd0);
        check("zc_idle",     64'(busy),         64'd0);
        check("zc_no_write", 64'(wr_cnt - w0),  64'd0);

        // ---------------- abort after 6 bytes ----------------
        w0 = wr_cnt;
        d0 = done_cnt;
        a0 = abort_cnt;
        start_load(16'h0020, 16'd2);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_pulse", 64'(aborted), 64'd1);
        check("ab_idle",  64'(busy),    64'd0);
        @(negedge clk);
        check("ab_pulse_off", 64'(aborted),       64'd0);
        check("ab_one_write", 64'(wr_cnt - w0),   64'd1);
        check("ab_wr_addr",   64'(wr_addr[w0]),   64'h0020);
        check("ab_wr_data",   64'(wr_data[w0]),   64'h33323130);
        check("ab_no_done",   64'(done_cnt - d0), 64'd0);
        check("ab_cnt",       64'(abort_cnt - a0), 64'd1);

        // ---------------- abort in a WRITE cycle ----------------
        w0 = wr_cnt;
        d0 = done_cnt;
        start_load(16'h0030, 16'd1);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h50 + i));
        abort = 1'b1;
        #1;
        check("abw_set_off", 64'(bus.o_set), 64'd0);
        @(negedge clk);
        abort = 1'b0;
        check("abw_pulse",    64'(aborted),       64'd1);
        @(negedge clk);
        check("abw_no_write", 64'(wr_cnt - w0),   64'd0);
        check("abw_no_done",  64'(done_cnt - d0), 64'd0);

        // ---------------- asynchronous reset mid-load ----------------
        start_load(16'h0040, 16'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy",  64'(busy),             64'd0);
        check("ar_ready", 64'(bus.o_byte_ready), 64'd0);
        check("ar_addr",  64'(bus.o_addr),       64'd0);
        check("ar_data",  64'(bus.o_data),       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        w0 = wr_cnt;
        start_load(16'h0050, 16'd1);
        send_byte(8'hDD);
        send_byte(8'hCC);
        send_byte(8'hBB);
        send_byte(8'hAA);
        check("ar_fresh_set",  64'(bus.o_set),  64'd1);
        check("ar_fresh_addr", 64'(bus.o_addr), 64'h0050);
        check("ar_fresh_data", 64'(bus.o_data), 64'hAABBCCDD);
        wait_idle();
        @(negedge clk);
        check("ar_fresh_count", 64'(wr_cnt - w0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
